// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        IMM = 2'd1,
        RET = 2'd2,
        INT = 2'd3
    } state_e;

    localparam int DEF_RET_BUBBLES  = 2;
    localparam int DEF_INTR_SEQ_LEN = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/intr_edge_latch.sv
// Rising-edge detector on the interrupt level with a sticky pending bit.
// Latency: pending rises one clock after the edge is sampled.
// Backpressure: pending holds until acknowledged; a held level never re-arms it.
//
// Ports: clk, reset (sync, active-low), intr_req (level in),
//        intr_ack (clears pending), intr_pend (registered pending flag).
module intr_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic intr_req,
    input  logic intr_ack,
    output logic intr_pend
);

    logic req_q, req_d;
    logic pend_q, pend_d;
    logic rise;

    always_comb begin
        req_d  = intr_req;
        rise   = intr_req & ~req_q;
        // A fresh edge in the acknowledge cycle is a new request and must
        // survive the clear, so set takes priority over ack.
        pend_d = rise | (pend_q & ~intr_ack);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            pend_q <= pend_d;
        end
    end

    assign intr_pend = pend_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller for the five-stage core: load-use, redirects, 2-byte fetch, interrupt entry.
// Latency: strobes are combinational (Mealy) from registered state and current inputs.
// Backpressure: asserts stall_F/stall_D to hold the front end; flush_D/flush_E insert bubbles.
//
// Ports: clk, reset (sync, active-low); hazard inputs from D/E (rd_en_E, wr_en_regf_E,
//        dest_E, RA_D, RB_D, use_ra_D, use_rb_D, is_2_byte_D, branch_taken_E, is_ret_E),
//        intr_req (level); outputs stall_F, stall_D, flush_D, flush_E, imm_capture,
//        nothing_here_D, force_intr_D, intr_ack, state_o (debug).
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int RET_BUBBLES  = DEF_RET_BUBBLES,
    parameter int INTR_SEQ_LEN = DEF_INTR_SEQ_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_en_E,
    input  logic       wr_en_regf_E,
    input  logic [1:0] dest_E,
    input  logic [1:0] RA_D,
    input  logic [1:0] RB_D,
    input  logic       use_ra_D,
    input  logic       use_rb_D,
    input  logic       is_2_byte_D,
    input  logic       branch_taken_E,
    input  logic       is_ret_E,
    input  logic       intr_req,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       imm_capture,
    output logic       nothing_here_D,
    output logic       force_intr_D,
    output logic       intr_ack,
    output logic [1:0] state_o
);

    localparam int CNT_W = $clog2(max2(RET_BUBBLES, INTR_SEQ_LEN) + 1);
    localparam logic [CNT_W-1:0] RET_CNT_INIT = CNT_W'(RET_BUBBLES - 1);
    localparam logic [CNT_W-1:0] INT_CNT_INIT = CNT_W'(INTR_SEQ_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             intr_pend;
    logic             haz;

    intr_edge_latch u_intr_edge_latch (
        .clk       (clk),
        .reset     (reset),
        .intr_req  (intr_req),
        .intr_ack  (intr_ack),
        .intr_pend (intr_pend)
    );

    always_comb begin
        haz = rd_en_E & wr_en_regf_E &
              ((use_ra_D & (RA_D == dest_E)) | (use_rb_D & (RB_D == dest_E)));

        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_F        = 1'b0;
        stall_D        = 1'b0;
        flush_D        = 1'b0;
        flush_E        = 1'b0;
        imm_capture    = 1'b0;
        nothing_here_D = 1'b0;
        force_intr_D   = 1'b0;
        intr_ack       = 1'b0;

        case (state_q)
            RUN: begin
                if (branch_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (is_ret_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                    stall_F = 1'b1;
                    state_d = RET;
                    cnt_d   = RET_CNT_INIT;
                end else if (haz) begin
                    // Re-evaluated every cycle: one bubble per dependent load.
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end else if (is_2_byte_D) begin
                    // PC keeps advancing so the immediate byte arrives next cycle.
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                    state_d = IMM;
                end else if (intr_pend) begin
                    intr_ack     = 1'b1;
                    force_intr_D = 1'b1;
                    stall_F      = 1'b1;
                    state_d      = INT;
                    cnt_d        = INT_CNT_INIT;
                end
            end
            IMM: begin
                // A redirect kills the half-fetched instruction entirely.
                if (branch_taken_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                    state_d = RUN;
                end else if (is_ret_E) begin
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                    stall_F = 1'b1;
                    state_d = RET;
                    cnt_d   = RET_CNT_INIT;
                end else begin
                    imm_capture    = 1'b1;
                    nothing_here_D = 1'b1;
                    state_d        = RUN;
                end
            end
            RET, INT: begin
                // EX only holds bubbles here, so branch_taken_E is not looked at.
                stall_F = 1'b1;
                flush_D = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (!reset) begin
            stall_F        = 1'b0;
            stall_D        = 1'b0;
            flush_D        = 1'b1;
            flush_E        = 1'b1;
            imm_capture    = 1'b0;
            nothing_here_D = 1'b0;
            force_intr_D   = 1'b0;
            intr_ack       = 1'b0;
        end

        state_o = reset ? state_q : RUN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    typedef struct packed {
        logic       rst_n;
        logic       rd;
        logic       wr;
        logic [1:0] dest;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       ura;
        logic       urb;
        logic       two;
        logic       br;
        logic       ret;
        logic       irq;
    } in_t;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } exp_t;

    logic clk;
    in_t  s;
    in_t  cur;
    exp_t sb_q[$];
    int   n_chk;
    int   n_fail;

    logic       stall_F, stall_D, flush_D, flush_E;
    logic       imm_capture, nothing_here_D, force_intr_D, intr_ack;
    logic [1:0] state_o;

    hazard_ctrl_unit #(.RET_BUBBLES(2), .INTR_SEQ_LEN(2)) dut (
        .clk            (clk),
        .reset          (cur.rst_n),
        .rd_en_E        (cur.rd),
        .wr_en_regf_E   (cur.wr),
        .dest_E         (cur.dest),
        .RA_D           (cur.ra),
        .RB_D           (cur.rb),
        .use_ra_D       (cur.ura),
        .use_rb_D       (cur.urb),
        .is_2_byte_D    (cur.two),
        .branch_taken_E (cur.br),
        .is_ret_E       (cur.ret),
        .intr_req       (cur.irq),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .imm_capture    (imm_capture),
        .nothing_here_D (nothing_here_D),
        .force_intr_D   (force_intr_D),
        .intr_ack       (intr_ack),
        .state_o        (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector order: sf sd fd fe ic nh fi ia st[1:0]
    function automatic logic [9:0] ex(input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic ic, input logic nh,
                                      input logic fi, input logic ia, input logic [1:0] st);
        return {sf, sd, fd, fe, ic, nh, fi, ia, st};
    endfunction

    // Apply the staged inputs for one cycle and queue the response they must produce.
    task automatic cyc(input string name, input logic [9:0] exp);
        exp_t item;
        @(posedge clk);
        #1;
        cur       = s;
        item.exp  = exp;
        item.name = name;
        sb_q.push_back(item);
    endtask

    task automatic clr();
        logic irq;
        irq     = s.irq;
        s       = '0;
        s.rst_n = 1'b1;
        s.irq   = irq;
    endtask

    // Monitor: compare every cycle that has an expectation queued.
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {stall_F, stall_D, flush_D, flush_E, imm_capture,
                       nothing_here_D, force_intr_D, intr_ack, state_o};
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b want %b (sf sd fd fe ic nh fi ia st)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        s      = '0;
        cur    = '0;

        // Reset: only the two flushes, even with events on the inputs
        cyc("rst0", ex(0,0,1,1,0,0,0,0,2'd0));
        s.ret = 1'b1; s.two = 1'b1;
        cyc("rst_gate", ex(0,0,1,1,0,0,0,0,2'd0));
        clr();
        cyc("idle0", ex(0,0,0,0,0,0,0,0,2'd0));

        // Load-use hazards
        s.rd = 1; s.wr = 1; s.dest = 2'd2; s.urb = 1; s.rb = 2'd2;
        cyc("lu_rb", ex(1,1,0,1,0,0,0,0,2'd0));
        clr();
        cyc("lu_after", ex(0,0,0,0,0,0,0,0,2'd0));
        s.rd = 1; s.wr = 0; s.dest = 2'd2; s.urb = 1; s.rb = 2'd2;
        cyc("no_wr", ex(0,0,0,0,0,0,0,0,2'd0));
        clr();
        s.rd = 1; s.wr = 1; s.dest = 2'd3; s.ra = 2'd3; s.ura = 0;
        cyc("ra_unused", ex(0,0,0,0,0,0,0,0,2'd0));
        s.ura = 1;
        cyc("lu_ra", ex(1,1,0,1,0,0,0,0,2'd0));
        s.two = 1;
        cyc("haz_over_2b", ex(1,1,0,1,0,0,0,0,2'd0));
        clr();
        cyc("haz_no_imm", ex(0,0,0,0,0,0,0,0,2'd0));

        // 2-byte instruction
        s.two = 1;
        cyc("2b_c0", ex(0,1,0,1,0,0,0,0,2'd0));
        clr();
        cyc("2b_c1", ex(0,0,0,0,1,1,0,0,2'd1));
        cyc("2b_c2", ex(0,0,0,0,0,0,0,0,2'd0));

        // RET with two bubbles; branch in RET ignored
        s.ret = 1;
        cyc("ret_c0", ex(1,0,1,1,0,0,0,0,2'd0));
        clr();
        cyc("ret_b1", ex(1,0,1,0,0,0,0,0,2'd2));
        s.br = 1;
        cyc("ret_b2_br", ex(1,0,1,0,0,0,0,0,2'd2));
        clr();
        cyc("ret_done", ex(0,0,0,0,0,0,0,0,2'd0));

        // Branch outranks RET
        s.br = 1; s.ret = 1;
        cyc("br_over_ret", ex(0,0,1,1,0,0,0,0,2'd0));
        clr();
        cyc("br_stay", ex(0,0,0,0,0,0,0,0,2'd0));

        // Interrupt level held for 10 cycles: one ack only
        s.irq = 1;
        cyc("irq_edge", ex(0,0,0,0,0,0,0,0,2'd0));
        cyc("irq_ack", ex(1,0,0,0,0,0,1,1,2'd0));
        cyc("int_1", ex(1,0,1,0,0,0,0,0,2'd3));
        cyc("int_2", ex(1,0,1,0,0,0,0,0,2'd3));
        for (int i = 0; i < 6; i++) cyc("irq_held", ex(0,0,0,0,0,0,0,0,2'd0));
        s.irq = 0;
        cyc("irq_low", ex(0,0,0,0,0,0,0,0,2'd0));

        // Branch + 2-byte + pending interrupt together
        s.irq = 1;
        cyc("irq_edge2", ex(0,0,0,0,0,0,0,0,2'd0));
        s.br = 1; s.two = 1;
        cyc("sim_br", ex(0,0,1,1,0,0,0,0,2'd0));
        clr();
        cyc("sim_ack", ex(1,0,0,0,0,0,1,1,2'd0));
        cyc("sim_int_1", ex(1,0,1,0,0,0,0,0,2'd3));
        cyc("sim_int_2", ex(1,0,1,0,0,0,0,0,2'd3));
        s.irq = 0;
        cyc("sim_idle", ex(0,0,0,0,0,0,0,0,2'd0));

        // Redirects while in IMM
        s.two = 1;
        cyc("imm_br_c0", ex(0,1,0,1,0,0,0,0,2'd0));
        clr(); s.br = 1;
        cyc("imm_br", ex(0,0,1,1,0,0,0,0,2'd1));
        clr();
        cyc("imm_br_run", ex(0,0,0,0,0,0,0,0,2'd0));
        s.two = 1;
        cyc("imm_ret_c0", ex(0,1,0,1,0,0,0,0,2'd0));
        clr(); s.ret = 1;
        cyc("imm_ret", ex(1,0,1,1,0,0,0,0,2'd1));
        clr();
        cyc("imm_ret_b1", ex(1,0,1,0,0,0,0,0,2'd2));
        cyc("imm_ret_b2", ex(1,0,1,0,0,0,0,0,2'd2));
        cyc("imm_ret_run", ex(0,0,0,0,0,0,0,0,2'd0));

        // Interrupt pending across IMM is deferred until RUN
        s.irq = 1; s.two = 1;
        cyc("2b_irq", ex(0,1,0,1,0,0,0,0,2'd0));
        s.two = 0;
        cyc("imm_no_int", ex(0,0,0,0,1,1,0,0,2'd1));
        cyc("int_after_imm", ex(1,0,0,0,0,0,1,1,2'd0));
        cyc("aimm_int_1", ex(1,0,1,0,0,0,0,0,2'd3));
        cyc("aimm_int_2", ex(1,0,1,0,0,0,0,0,2'd3));
        s.irq = 0;
        cyc("aimm_idle", ex(0,0,0,0,0,0,0,0,2'd0));

        // Reset in the middle of RET, with an interrupt just latched
        s.ret = 1;
        cyc("ret2_c0", ex(1,0,1,1,0,0,0,0,2'd0));
        clr(); s.irq = 1;
        cyc("ret2_b1_irq", ex(1,0,1,0,0,0,0,0,2'd2));
        s.irq = 0; s.rst_n = 0;
        cyc("rst_mid", ex(0,0,1,1,0,0,0,0,2'd0));
        s.rst_n = 1;
        cyc("post_rst_0", ex(0,0,0,0,0,0,0,0,2'd0));
        cyc("post_rst_1", ex(0,0,0,0,0,0,0,0,2'd0));

        @(negedge clk);
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
